// File: rtl/reg_bank_pkg.sv
// Shared definitions for the index/stack register bank: op encoding and
// the per-register update function used by both the lanes and the bypass path.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } op_e;

    // Widest register the shared update function can handle.
    localparam int unsigned MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0] word_t;

    // Returns {wrap, new}; the caller keeps only the low `width` bits of new.
    function automatic logic [MAX_WIDTH:0] next_value(
        input op_e         op,
        input word_t       old,
        input word_t       wdata,
        input int unsigned width
    );
        word_t mask;
        word_t nv;
        logic  wrap;
        mask = (width >= MAX_WIDTH) ? {MAX_WIDTH{1'b1}}
                                    : ((word_t'(1) << width) - word_t'(1));
        nv   = old;
        wrap = 1'b0;
        case (op)
            OP_LOAD: begin
                nv   = wdata;
                wrap = 1'b0;
            end
            OP_INC: begin
                nv   = old + word_t'(1);
                wrap = ((old & mask) == mask);
            end
            OP_DEC: begin
                nv   = old - word_t'(1);
                wrap = ((old & mask) == '0);
            end
            default: begin
                nv   = old;
                wrap = 1'b0;
            end
        endcase
        return {wrap, nv & mask};
    endfunction

endpackage

// File: rtl/reg_lane.sv
// One register of the bank: stores its value and exposes the value it
// would take if the presented op were applied this cycle.
module reg_lane
    import reg_bank_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply_i,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    logic [MAX_WIDTH:0] res;
    logic [WIDTH-1:0]   val_q;
    logic [WIDTH-1:0]   val_d;

    // Candidate result of the op on this lane's current value.
    always_comb begin
        res = next_value(op_i, word_t'(val_q), word_t'(wdata_i), WIDTH);
    end

    assign next_o = res[WIDTH-1:0];
    assign wrap_o = res[MAX_WIDTH];
    assign q_o    = val_q;

    // Bits above WIDTH are always zero after masking.
    if (WIDTH < MAX_WIDTH) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^res[MAX_WIDTH-1:WIDTH];
    end

    // Take the candidate only when this lane is the applied target.
    always_comb begin
        val_d = val_q;
        if (apply_i) begin
            val_d = next_o;
        end
    end

    // Register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= RESET_VALUE;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/reg_bank_ctr.sv
// Bank of CHANNELS index/stack registers with hold/load/inc/dec updates,
// two combinational read ports with optional write bypass, and
// zero/negative/wrap flags describing the last applied op.
module reg_bank_ctr
    import reg_bank_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      CHANNELS    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               BYPASS      = 1'b1,
    localparam int unsigned     SELW        = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [SELW-1:0]  wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [SELW-1:0]  rsel_a,
    input  logic [SELW-1:0]  rsel_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             zero,
    output logic             neg,
    output logic             wrap
);

    op_e                 op_v;
    logic [CHANNELS-1:0] lane_hit;
    logic [CHANNELS-1:0] lane_apply;
    logic [CHANNELS-1:0] lane_wrap;
    logic [WIDTH-1:0]    lane_q    [CHANNELS];
    logic [WIDTH-1:0]    lane_next [CHANNELS];
    logic                applied;
    logic [WIDTH-1:0]    sel_next;
    logic                sel_wrap;
    logic                zero_q, zero_d;
    logic                neg_q,  neg_d;
    logic                wrap_q, wrap_d;

    assign op_v = op_e'(op);

    // Decode wsel; an out-of-range select hits no lane and is dropped.
    always_comb begin
        lane_hit   = '0;
        lane_apply = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            lane_hit[i]   = (wsel == SELW'(i));
            lane_apply[i] = lane_hit[i] && (op_v != OP_HOLD) && !rst;
        end
    end

    assign applied = |lane_apply;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_lane
        reg_lane #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .apply_i (lane_apply[g]),
            .op_i    (op_v),
            .wdata_i (wdata),
            .q_o     (lane_q[g]),
            .next_o  (lane_next[g]),
            .wrap_o  (lane_wrap[g])
        );
    end

    // Result of the targeted lane, feeding flags and bypass.
    always_comb begin
        sel_next = '0;
        sel_wrap = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (lane_hit[i]) begin
                sel_next = lane_next[i];
                sel_wrap = lane_wrap[i];
            end
        end
    end

    // Flags follow the last applied op and hold otherwise.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        wrap_d = wrap_q;
        if (applied) begin
            zero_d = (sel_next == '0);
            neg_d  = sel_next[WIDTH-1];
            wrap_d = sel_wrap;
        end
    end

    // Flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            wrap_q <= wrap_d;
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign wrap = wrap_q;

    // Read port A: stored value, zero when out of range, optional bypass.
    always_comb begin
        rdata_a = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (rsel_a == SELW'(i)) begin
                rdata_a = lane_q[i];
            end
        end
        if (BYPASS && applied && (rsel_a == wsel)) begin
            rdata_a = sel_next;
        end
    end

    // Read port B: same structure as port A, independent select.
    always_comb begin
        rdata_b = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (rsel_b == SELW'(i)) begin
                rdata_b = lane_q[i];
            end
        end
        if (BYPASS && applied && (rsel_b == wsel)) begin
            rdata_b = sel_next;
        end
    end

endmodule

// File: doc/reg_bank_ctr.md
# reg_bank_ctr

Parametrised register bank that generalises the single 8-bit enabled register into CHANNELS registers of WIDTH bits. Each write cycle applies one of hold, load, increment or decrement to the selected register. Two combinational read ports can optionally bypass the result being written in the same cycle. The block provides the 6502 index and stack registers (X, Y, SP and similar), updating them directly without going through the ALU, and reports zero, negative and wrap flags for the last operation.

## Interface
- WIDTH, 8: bits per register, ≥2
- CHANNELS, 4: number of registers, ≥2
- RESET_VALUE, 0: WIDTH-bit value loaded into every register on reset
- BYPASS, 1: 1 = read ports forward the same-cycle write result; 0 = read ports return stored state only
- SELW, $clog2(CHANNELS): localparam, select width
- clk  in  1  single clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  2  00 HOLD, 01 LOAD, 10 INC, 11 DEC
- wsel  in  SELW  target register of op
- wdata  in  WIDTH  value for LOAD; ignored otherwise
- rsel_a  in  SELW  read port A select
- rsel_b  in  SELW  read port B select
- rdata_a  out  WIDTH  read port A data, combinational
- rdata_b  out  WIDTH  read port B data, combinational
- zero  out  1  registered: last applied result == 0
- neg  out  1  registered: last applied result MSB
- wrap  out  1  registered: last INC/DEC wrapped modulo 2^WIDTH

## Operation
- An op is "applied" when op != HOLD, wsel < CHANNELS and rst = 0. Only the register at wsel changes. All other registers hold.
- LOAD: reg ← wdata. wrap ← 0.
- INC: reg ← reg + 1 mod 2^WIDTH. wrap ← (old == all-ones).
- DEC: reg ← reg − 1 mod 2^WIDTH. wrap ← (old == 0).
- Every applied op sets zero ← (new == 0) and neg ← new[WIDTH-1].
- HOLD, or wsel ≥ CHANNELS: no register or flag change. An out-of-range wsel is silently ignored.
- Read: rdata_x = register[rsel_x]. If rsel_x ≥ CHANNELS, rdata_x = 0.
- Bypass (BYPASS=1): if an op is applied this cycle and rsel_x == wsel, rdata_x shows the value the register will hold after the edge. Both ports bypass independently and can hit the same register.
- BYPASS=0: rdata_x always reflects stored state. The write becomes visible the cycle after the edge.
- Reset: rst=1 at an edge sets all registers ← RESET_VALUE and zero=neg=wrap ← 0.
  - Reset overrides any op in the same cycle.
  - Bypass is suppressed while rst=1, so reads show stored state.
- Reset arriving mid-sequence (e.g. during an INC burst) discards that cycle's op. No op is pending across reset.

## Timing
- Write latency: 1 cycle. The register and flags update on the rising edge where the op is presented.
- Read latency: 0 cycles (combinational from storage, plus the bypass mux when BYPASS=1).
- Back-to-back ops on the same register are allowed every cycle, e.g. INC,INC,INC advances by 3 in 3 cycles.
- Flags change only on an applied edge and hold otherwise, including across HOLD cycles.
- Outputs after reset: every register = RESET_VALUE, rdata_a/b = RESET_VALUE for in-range selects, zero=0, neg=0, wrap=0.
- There is no handshake. The caller must hold op=HOLD when no update is intended.

## Structure
- Package reg_bank_pkg:
  - op encoding constants/enum: OP_HOLD, OP_LOAD, OP_INC, OP_DEC
  - a function next_value(op, old, wdata) returning {wrap, new}, shared by the lane and the bypass path
- Sub-module reg_lane: one WIDTH-bit register with sync reset to RESET_VALUE, an apply input, op and wdata. It outputs the stored value and the next value.
- reg_bank_ctr instantiates CHANNELS lanes via generate and contains:
  - the wsel decode
  - the flag registers
  - the two read muxes with bypass

## Test plan
- Reset: preload regs with nonzero values, assert rst for 1 cycle → all regs read 0x00; zero/neg/wrap = 0. With op=LOAD present during rst, the load is not applied.
- LOAD/bypass (BYPASS=1): LOAD 0x80 to ch1 with rsel_a=1 → rdata_a = 0x80 in the same cycle. After the edge: neg=1, zero=0.
- No bypass (BYPASS=0): same LOAD → rdata_a holds the old value in that cycle and shows 0x80 the next cycle.
- Wrap: LOAD 0xFF to ch2, then INC → 0x00, zero=1, wrap=1. Then DEC → 0xFF, neg=1, wrap=1. Then LOAD 0x05 → wrap=0.
- Out of range (CHANNELS=3): INC with wsel=3 → no register or flag change. rsel_b=3 → rdata_b = 0x00.
- Parametrised run (WIDTH=16, CHANNELS=8, RESET_VALUE=0x01FF): after reset all regs = 0x01FF. 256 INCs on ch7 → 0x02FF, wrap=0. Random op stream checked against a reference model.
